actuator_power_arbiter: RTL and testbench

ACTUATOR_POWER_ARBITER -- requirements
Module: actuator_power_arbiter

---
 rtl/actuator_power_arbiter.sv | 175 +++++++++++++++++
 tb/tb_actuator_power_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/actuator_power_arbiter.sv
// Power-budget arbiter for heater, cooler and light loads: round-robin grants,
// minimum on/off hold times, heater/cooler exclusion and alarm-driven load shedding.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// ST_OFF      | released and idle; may be granted when eligible
// ST_ON_HOLD  | granted, minimum on-time running; req ignored
// ST_ON       | granted, stays on while req is held
// ST_OFF_HOLD | released, minimum off-time running; req ignored
module actuator_power_arbiter #(
    parameter logic [8:0] BUDGET  = 9'd160,
    parameter logic [8:0] COST_H  = 9'd96,
    parameter logic [8:0] COST_C  = 9'd96,
    parameter logic [8:0] COST_L  = 9'd32,
    parameter logic [7:0] MIN_ON  = 8'd16,
    parameter logic [7:0] MIN_OFF = 8'd16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] req,
    input  logic       alarm_in,
    output logic [2:0] grant,
    output logic [8:0] load_sum,
    output logic       shed
);

    typedef enum logic [1:0] {
        ST_OFF      = 2'd0,
        ST_ON_HOLD  = 2'd1,
        ST_ON       = 2'd2,
        ST_OFF_HOLD = 2'd3
    } chan_state_e;

    chan_state_e state_q [3];
    chan_state_e state_d [3];
    logic [7:0]  cnt_q   [3];
    logic [7:0]  cnt_d   [3];
    logic [1:0]  ptr_q, ptr_d;
    logic [2:0]  grant_q, grant_d;
    logic [8:0]  load_sum_q, load_sum_d;
    logic        shed_q, shed_d;

    logic [8:0]  cost_w [3];
    logic [2:0]  active;
    logic [2:0]  fits;
    logic [2:0]  elig;
    logic        pick_vld;
    logic [1:0]  pick_idx;
    logic [2:0]  cand_sum;
    logic [1:0]  cand;
    logic        shed_cond;

    assign cost_w[0] = COST_H;
    assign cost_w[1] = COST_C;
    assign cost_w[2] = COST_L;

    // Budget check uses the registered sum, so budget freed by a release this
    // cycle only becomes usable on the following cycle.
    always_comb begin
        active = '0;
        fits   = '0;
        elig   = '0;
        for (int i = 0; i < 3; i++) begin
            active[i] = (state_q[i] == ST_ON_HOLD) || (state_q[i] == ST_ON);
            fits[i]   = ({1'b0, load_sum_q} + {1'b0, cost_w[i]}) <= {1'b0, BUDGET};
            elig[i]   = (state_q[i] == ST_OFF) && req[i] && !alarm_in && fits[i];
        end
        if (active[1]) elig[0] = 1'b0;
        if (active[0]) elig[1] = 1'b0;
    end

    // Descending scan so the candidate closest to the pointer wins.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = 2'd0;
        cand_sum = 3'd0;
        cand     = 2'd0;
        for (int k = 2; k >= 0; k--) begin
            cand_sum = {1'b0, ptr_q} + 3'(k);
            cand     = (cand_sum >= 3'd3) ? 2'(cand_sum - 3'd3) : cand_sum[1:0];
            if (elig[cand]) begin
                pick_vld = 1'b1;
                pick_idx = cand;
            end
        end
    end

    assign shed_cond = alarm_in && (grant_q != 3'b000);

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 3; i++) begin
                state_q[i] <= ST_OFF;
                cnt_q[i]   <= 8'd0;
            end
            ptr_q      <= 2'd0;
            grant_q    <= 3'b000;
            load_sum_q <= 9'd0;
            shed_q     <= 1'b0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            ptr_q      <= ptr_d;
            grant_q    <= grant_d;
            load_sum_q <= load_sum_d;
            shed_q     <= shed_d;
        end
    end

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            case (state_q[i])
                ST_OFF: begin
                    if (pick_vld && (pick_idx == 2'(i))) begin
                        state_d[i] = ST_ON_HOLD;
                        cnt_d[i]   = MIN_ON - 8'd1;
                    end
                end
                ST_ON_HOLD: begin
                    if (shed_cond) begin
                        state_d[i] = ST_OFF_HOLD;
                        cnt_d[i]   = MIN_OFF - 8'd1;
                    end else if (cnt_q[i] == 8'd0) begin
                        state_d[i] = ST_ON;
                    end else begin
                        cnt_d[i] = cnt_q[i] - 8'd1;
                    end
                end
                ST_ON: begin
                    if (shed_cond || !req[i]) begin
                        state_d[i] = ST_OFF_HOLD;
                        cnt_d[i]   = MIN_OFF - 8'd1;
                    end
                end
                ST_OFF_HOLD: begin
                    if (cnt_q[i] == 8'd0) begin
                        state_d[i] = ST_OFF;
                    end else begin
                        cnt_d[i] = cnt_q[i] - 8'd1;
                    end
                end
                default: begin
                    state_d[i] = ST_OFF;
                    cnt_d[i]   = 8'd0;
                end
            endcase
        end

        ptr_d = ptr_q;
        if (pick_vld) begin
            ptr_d = (pick_idx == 2'd2) ? 2'd0 : pick_idx + 2'd1;
        end
    end

    // Grant and load_sum are derived from the next state so they change together.
    always_comb begin
        grant_d = 3'b000;
        for (int i = 0; i < 3; i++) begin
            grant_d[i] = (state_d[i] == ST_ON_HOLD) || (state_d[i] == ST_ON);
        end
        load_sum_d = (grant_d[0] ? COST_H : 9'd0)
                   + (grant_d[1] ? COST_C : 9'd0)
                   + (grant_d[2] ? COST_L : 9'd0);
        shed_d     = shed_cond;
    end

    assign grant    = grant_q;
    assign load_sum = load_sum_q;
    assign shed     = shed_q;

endmodule

// File: tb/tb_actuator_power_arbiter.sv
// Scoreboard bench: a time-based reference model predicts both a default and a
// tight-budget arbiter; a monitor compares every cycle's outputs against the queue.
module tb_actuator_power_arbiter;

    localparam int MIN_ON_M  = 16;
    localparam int MIN_OFF_M = 16;

    logic       clk;
    logic       rst;
    logic [2:0] req;
    logic       alarm_in;
    logic [2:0] grant_a, grant_b;
    logic [8:0] load_sum_a, load_sum_b;
    logic       shed_a, shed_b;

    actuator_power_arbiter dut_a (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .alarm_in (alarm_in),
        .grant    (grant_a),
        .load_sum (load_sum_a),
        .shed     (shed_a)
    );

    actuator_power_arbiter #(.BUDGET(9'd100)) dut_b (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .alarm_in (alarm_in),
        .grant    (grant_b),
        .load_sum (load_sum_b),
        .shed     (shed_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] g0;
        logic [8:0] l0;
        logic       s0;
        logic [2:0] g1;
        logic [8:0] l1;
        logic       s1;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   edge_n   = 0;

    int cost_m   [3] = '{96, 96, 32};
    int budget_m [2] = '{160, 100};
    bit on_m     [2][3];
    bit free_m   [2][3];
    int t_m      [2][3];
    int ptr_m    [2];
    bit shed_m   [2];

    // Each channel is described by whether it is on and the edge of its last
    // change; hold times are checked as elapsed-edge distances.
    task automatic model_step(input int u, input int e, input bit rst_v,
                              input bit [2:0] rq, input bit al);
        bit on0 [3];
        bit el  [3];
        int sum;
        bit any;
        bit found;
        int c;
        if (!rst_v) begin
            for (int i = 0; i < 3; i++) begin
                on_m[u][i]   = 1'b0;
                free_m[u][i] = 1'b1;
                t_m[u][i]    = 0;
            end
            ptr_m[u]  = 0;
            shed_m[u] = 1'b0;
            return;
        end
        sum = 0;
        any = 1'b0;
        for (int i = 0; i < 3; i++) begin
            on0[i] = on_m[u][i];
            if (on0[i]) sum += cost_m[i];
            any |= on0[i];
        end
        shed_m[u] = 1'b0;
        if (al && any) begin
            for (int i = 0; i < 3; i++) begin
                if (on0[i]) begin
                    on_m[u][i]   = 1'b0;
                    free_m[u][i] = 1'b0;
                    t_m[u][i]    = e;
                end
            end
            shed_m[u] = 1'b1;
            return;
        end
        for (int i = 0; i < 3; i++) begin
            el[i] = !on0[i] && (free_m[u][i] || (e - t_m[u][i] >= MIN_OFF_M + 1))
                    && rq[i] && !al && (sum + cost_m[i] <= budget_m[u]);
        end
        if (on0[1]) el[0] = 1'b0;
        if (on0[0]) el[1] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (on0[i] && !rq[i] && (e - t_m[u][i] >= MIN_ON_M + 1)) begin
                on_m[u][i]   = 1'b0;
                free_m[u][i] = 1'b0;
                t_m[u][i]    = e;
            end
        end
        found = 1'b0;
        for (int k = 0; k < 3; k++) begin
            c = (ptr_m[u] + k) % 3;
            if (!found && el[c]) begin
                found      = 1'b1;
                on_m[u][c] = 1'b1;
                t_m[u][c]  = e;
                ptr_m[u]   = (c + 1) % 3;
            end
        end
    endtask

    function automatic logic [2:0] grant_of(input int u);
        logic [2:0] g;
        for (int i = 0; i < 3; i++) g[i] = on_m[u][i];
        return g;
    endfunction

    function automatic logic [8:0] sum_of(input int u);
        int s;
        s = 0;
        for (int i = 0; i < 3; i++) if (on_m[u][i]) s += cost_m[i];
        return 9'(s);
    endfunction

    task automatic drive_step(input bit r, input bit [2:0] q, input bit a);
        exp_t x;
        @(negedge clk);
        rst      = r;
        req      = q;
        alarm_in = a;
        edge_n++;
        for (int u = 0; u < 2; u++) model_step(u, edge_n, r, q, a);
        x.g0 = grant_of(0);
        x.l0 = sum_of(0);
        x.s0 = shed_m[0];
        x.g1 = grant_of(1);
        x.l1 = sum_of(1);
        x.s1 = shed_m[1];
        exp_q.push_back(x);
    endtask

    task automatic check(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            failures++;
            $display("FAIL %s edge=%0d actual=%0d required=%0d", name, edge_n, act, exp_v);
        end
    endtask

    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                check("grant_a",    int'(grant_a),    int'(x.g0));
                check("load_sum_a", int'(load_sum_a), int'(x.l0));
                check("shed_a",     int'(shed_a),     int'(x.s0));
                check("grant_b",    int'(grant_b),    int'(x.g1));
                check("load_sum_b", int'(load_sum_b), int'(x.l1));
                check("shed_b",     int'(shed_b),     int'(x.s1));
            end
        end
    end

    initial begin
        logic [2:0] rq;
        logic       al;
        int         alarm_left;
        rst      = 1'b0;
        req      = 3'b000;
        alarm_in = 1'b0;

        repeat (2)  drive_step(1'b0, 3'b000, 1'b0);
        // Single light request dropped early; minimum on-time keeps it granted.
        repeat (3)  drive_step(1'b1, 3'b100, 1'b0);
        repeat (40) drive_step(1'b1, 3'b000, 1'b0);
        // All three requests from reset: heater, then light; cooler excluded.
        repeat (2)  drive_step(1'b0, 3'b000, 1'b0);
        repeat (6)  drive_step(1'b1, 3'b111, 1'b0);
        // Alarm while heater and light are still in minimum on-time.
        repeat (5)  drive_step(1'b1, 3'b101, 1'b1);
        repeat (30) drive_step(1'b1, 3'b101, 1'b0);
        // Release into off-hold, then a one-cycle reset discards the hold.
        repeat (20) drive_step(1'b1, 3'b000, 1'b0);
        drive_step(1'b0, 3'b000, 1'b0);
        repeat (4)  drive_step(1'b1, 3'b001, 1'b0);

        rq         = 3'b000;
        alarm_left = 0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 5) == 0) rq[$urandom_range(0, 2)] ^= 1'b1;
            if (alarm_left > 0) begin
                alarm_left--;
                al = 1'b1;
            end else begin
                al = 1'b0;
                if ($urandom_range(0, 59) == 0) alarm_left = $urandom_range(1, 6);
            end
            drive_step(($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1, rq, al);
        end

        repeat (3) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
